// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the windowed-register core: drives the shared memory
// port over req/ack, sequences PC/IR/ALU/regfile/window updates, parks on memory timeout.
module multicycle_controller #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned WIN_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       opcode,
   input  logic [7:0]       func,
   input  logic             alu_zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             immdSel,
   output logic             memOrALU,
   output logic             reg_write,
   output logic [6:0]       ALUop,
   output logic [WIN_W-1:0] window,
   output logic             illegal_op,
   output logic             fault
);

   // state    | meaning
   // S_IDLE   | first cycle out of reset
   // S_FETCH  | instruction read on the memory port, waits for ack
   // S_DECODE | opcode dispatch, flags undefined opcodes
   // S_EXEC   | ALU operation / window update / compare
   // S_WB     | ALU result written to register file
   // S_MEM    | data load or store on the memory port
   // S_LWB    | load data written to register file
   // S_JUMP   | PC takes jump target
   // S_BRANCH | PC takes branch target when alu_zero
   // S_FAULT  | memory timeout, absorbing until reset
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB,
      S_MEM, S_LWB, S_JUMP, S_BRANCH, S_FAULT
   } state_t;

   localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [WIN_W-1:0] window_q, window_d;
   logic [6:0]       exec_alu;
   logic             exec_imm;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         wait_q   <= 8'd0;
         window_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         window_q <= window_d;
      end
   end

   always_comb begin
      exec_alu = 7'b0000000;
      exec_imm = 1'b0;
      case (opcode)
         4'b1000: exec_alu = func[6:0];
         4'b1100: begin exec_alu = 7'b0000010; exec_imm = 1'b1; end
         4'b1101: begin exec_alu = 7'b0000100; exec_imm = 1'b1; end
         4'b1110: begin exec_alu = 7'b0001000; exec_imm = 1'b1; end
         4'b1111: begin exec_alu = 7'b0010000; exec_imm = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      window_d   = window_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      immdSel    = 1'b0;
      memOrALU   = 1'b1;
      reg_write  = 1'b0;
      ALUop      = 7'b0000000;
      illegal_op = 1'b0;
      fault      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_q == TO_CNT) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            case (opcode)
               4'b0000, 4'b0001: state_d = S_MEM;
               4'b0010:          state_d = S_JUMP;
               4'b0100:          state_d = S_BRANCH;
               4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: state_d = S_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            ALUop   = exec_alu;
            immdSel = exec_imm;
            if (opcode == 4'b1000 && func[7]) begin
               window_d = func[WIN_W-1:0];
               state_d  = S_FETCH;
            end else if (opcode == 4'b1000 && func[7:6] == 2'b01) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            ALUop     = exec_alu;
            immdSel   = exec_imm;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = (opcode == 4'b0001);
            if (mem_ack) begin
               state_d = (opcode == 4'b0001) ? S_FETCH : S_LWB;
            end else if (wait_q == TO_CNT) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_LWB: begin
            reg_write = 1'b1;
            memOrALU  = 1'b0;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUop    = 7'b1000111;
            pc_src   = 2'd2;
            pc_write = alu_zero;
            state_d  = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: state_d = S_IDLE;
      endcase
      // watchdog restarts on every entry into a memory-waiting state
      if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
         wait_d = 8'd0;
   end

   assign window = window_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// output sequence, which also schedules mem_ack/alu_zero; the DUT is compared every cycle.
module tb_multicycle_controller;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [7:0] func = 8'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_write, iord, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       immdSel, memOrALU, reg_write;
   logic [6:0] ALUop;
   logic [1:0] window;
   logic       illegal_op, fault;

   multicycle_controller #(.TIMEOUT(TO), .WIN_W(2)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alu_zero(alu_zero),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .immdSel(immdSel),
      .memOrALU(memOrALU), .reg_write(reg_write), .ALUop(ALUop), .window(window),
      .illegal_op(illegal_op), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] outs;
      logic        ack;
      logic        az;
      logic [3:0]  op;
      logic [7:0]  fn;
      logic [1:0]  win;
   } cyc_t;

   cyc_t       q[$];
   logic [1:0] mwin;
   bit         faulted;
   int         total = 0;
   int         bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [18:0] pk(bit req, bit mw, bit io, bit irw, bit pcw, logic [1:0] pcs,
                                      bit imm, bit mor, bit rw, logic [6:0] alu, bit ill, bit flt);
      return {req, mw, io, irw, pcw, pcs, imm, mor, rw, alu, ill, flt};
   endfunction

   function automatic logic [18:0] nop_outs();
      return pk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 7'd0, 0, 0);
   endfunction

   task automatic push(input logic [18:0] o, input logic ack, input logic az,
                       input logic [3:0] op, input logic [7:0] fn);
      cyc_t c;
      c.outs = o; c.ack = ack; c.az = az; c.op = op; c.fn = fn; c.win = mwin;
      q.push_back(c);
   endtask

   // waits = cycles without ack before the ack cycle; beyond TO the core faults
   task automatic wait_mem(input bit is_mem, input bit st, input int waits,
                           input logic [3:0] op, input logic [7:0] fn);
      logic [18:0] w;
      int n;
      w = is_mem ? pk(1, st, 1, 0, 0, 2'd0, 0, 1, 0, 7'd0, 0, 0)
                 : pk(1, 0, 0, 0, 0, 2'd0, 0, 1, 0, 7'd0, 0, 0);
      n = (waits > TO) ? TO + 1 : waits;
      for (int i = 0; i < n; i++) push(w, 1'b0, 1'($urandom_range(0, 1)), op, fn);
      if (waits > TO) begin
         faulted = 1'b1;
         for (int i = 0; i < 3; i++)
            push(pk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 7'd0, 0, 1), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), op, fn);
      end else if (is_mem) begin
         push(w, 1'b1, 1'($urandom_range(0, 1)), op, fn);
      end else begin
         push(pk(1, 0, 0, 1, 1, 2'd0, 0, 1, 0, 7'd0, 0, 0), 1'b1, 1'($urandom_range(0, 1)), op, fn);
      end
   endtask

   task automatic add_instr(input logic [3:0] op, input logic [7:0] fn, input int fw,
                            input int mw, input logic az);
      logic [6:0] alu;
      bit imm, ill;
      wait_mem(0, 0, fw, op, fn);
      if (faulted) return;
      ill = !(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, [4'd12:4'd15]});
      push(pk(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 7'd0, ill, 0), 1'b0, 1'($urandom_range(0, 1)), op, fn);
      if (ill) return;
      case (op)
         4'd0, 4'd1: begin
            wait_mem(1, op == 4'd1, mw, op, fn);
            if (faulted) return;
            if (op == 4'd0)
               push(pk(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 7'd0, 0, 0), 1'b0, 1'($urandom_range(0, 1)), op, fn);
         end
         4'd2: push(pk(0, 0, 0, 0, 1, 2'd1, 0, 1, 0, 7'd0, 0, 0), 1'b0, 1'($urandom_range(0, 1)), op, fn);
         4'd4: push(pk(0, 0, 0, 0, az, 2'd2, 0, 1, 0, 7'b1000111, 0, 0), 1'b0, az, op, fn);
         default: begin
            imm = (op != 4'd8);
            alu = (op == 4'd8)  ? fn[6:0] :
                  (op == 4'd12) ? 7'd2 :
                  (op == 4'd13) ? 7'd4 :
                  (op == 4'd14) ? 7'd8 : 7'd16;
            push(pk(0, 0, 0, 0, 0, 2'd0, imm, 1, 0, alu, 0, 0), 1'b0, 1'($urandom_range(0, 1)), op, fn);
            if (op == 4'd8 && fn[7]) mwin = fn[1:0];
            else if (!(op == 4'd8 && fn[7:6] == 2'b01))
               push(pk(0, 0, 0, 0, 0, 2'd0, imm, 1, 1, alu, 0, 0), 1'b0, 1'($urandom_range(0, 1)), op, fn);
         end
      endcase
   endtask

   // entered and left just after a rising edge
   task automatic run_queue(input int limit);
      cyc_t c;
      int n = 0;
      while (q.size() > 0 && n < limit) begin
         c = q.pop_front();
         mem_ack = c.ack; alu_zero = c.az; opcode = c.op; func = c.fn;
         @(negedge clk);
         check_val("outs", 32'({mem_req, mem_write, iord, ir_write, pc_write, pc_src, immdSel,
                                memOrALU, reg_write, ALUop, illegal_op, fault}), 32'(c.outs));
         check_val("window", 32'(window), 32'(c.win));
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      check_val("rst_outs", 32'({mem_req, mem_write, iord, ir_write, pc_write, pc_src, immdSel,
                                 memOrALU, reg_write, ALUop, illegal_op, fault}), 32'(nop_outs()));
      check_val("rst_window", 32'(window), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      mwin = 2'd0; faulted = 1'b0;
      q.delete();
      push(nop_outs(), 1'b0, 1'b0, 4'd0, 8'd0);
   endtask

   task automatic do_instr(input logic [3:0] op, input logic [7:0] fn, input int fw,
                           input int mw, input logic az);
      add_instr(op, fn, fw, mw, az);
      run_queue(1000);
      if (faulted) do_reset();
   endtask

   initial begin
      int op, fw, mw, lim;
      logic [7:0] fn;
      @(posedge clk); #1;
      do_reset();
      do_instr(4'd12, 8'h5a, 0, 0, 1'b0);
      do_instr(4'd0, 8'h00, 0, 3, 1'b0);
      do_instr(4'd1, 8'h00, 1, 0, 1'b0);
      do_instr(4'd8, 8'b1000_0011, 0, 0, 1'b0);
      do_instr(4'd8, 8'b0100_0001, 0, 0, 1'b0);
      do_instr(4'd8, 8'b0000_0110, 0, 0, 1'b0);
      do_instr(4'd4, 8'h00, 0, 0, 1'b1);
      do_instr(4'd4, 8'h00, 0, 0, 1'b0);
      do_instr(4'd2, 8'h00, 0, 0, 1'b0);
      do_instr(4'd5, 8'h00, 0, 0, 1'b0);
      do_instr(4'd13, 8'h00, TO, 0, 1'b0);
      do_instr(4'd0, 8'h00, 0, TO, 1'b0);
      do_instr(4'd14, 8'h00, TO + 1, 0, 1'b0);
      do_instr(4'd8, 8'b1000_0010, 0, 0, 1'b0);
      do_instr(4'd1, 8'h00, 0, TO + 1, 1'b0);
      do_instr(4'd15, 8'h00, 0, 0, 1'b0);
      for (int k = 0; k < 300; k++) begin
         op = $urandom_range(0, 15);
         fn = 8'($urandom);
         fw = ($urandom_range(0, 24) == 0) ? TO + 1 : $urandom_range(0, TO);
         mw = ($urandom_range(0, 24) == 0) ? TO + 1 : $urandom_range(0, TO);
         add_instr(4'(op), fn, fw, mw, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 19) == 0 && q.size() > 1) begin
            lim = $urandom_range(1, q.size() - 1);
            run_queue(lim);
            do_reset();
         end else begin
            run_queue(1000);
            if (faulted) do_reset();
         end
      end
      run_queue(1000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 4-bit-opcode / 8-bit-func windowed-register processor.
- Replaces single-cycle decode with an FSM that drives a shared instruction/data memory port through a req/ack handshake.
- Sequences PC, IR, ALU, register-file write and register-window pointer updates.
- Adds a memory-timeout watchdog that parks the core in a fault state.

Parameters:
TIMEOUT, 15, max wait cycles with mem_req high and no mem_ack before entering FAULT (1..255)
WIN_W, 2, width of register-window pointer (2^WIN_W windows)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
opcode  in  4  IR[opcode] field; valid from DECODE onward
func  in  8  IR[func] field; valid from DECODE onward
alu_zero  in  1  ALU zero flag, same-cycle combinational
mem_ack  in  1  memory accepted/completed current request
mem_req  out  1  memory request strobe
mem_write  out  1  write qualifier for mem_req
iord  out  1  memory address select: 0 = PC, 1 = ALU/data address
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  2  0 = PC+1, 1 = jump target, 2 = branch target
immdSel  out  1  ALU B operand: 1 = immediate
memOrALU  out  1  writeback source: 0 = memory, 1 = ALU
reg_write  out  1  register-file write enable
ALUop  out  7  ALU operation
window  out  WIN_W  current register-window pointer (registered)
illegal_op  out  1  one-cycle pulse on undefined opcode
fault  out  1  sticky memory-timeout flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, MEM, LWB, JUMP, BRANCH, FAULT.
- Reset: rst low → state = IDLE, window = 0, wait counter = 0, fault = 0. All outputs 0, except memOrALU = 1 and pc_src = 0.
- IDLE: all strobes 0. Next cycle → FETCH.
- FETCH: mem_req = 1, iord = 0, mem_write = 0.
  - On mem_ack (may arrive in the same cycle as req): ir_write = 1, pc_write = 1, pc_src = 0 → DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0000 → MEM (load); 0001 → MEM (store); 0010 → JUMP; 0100 → BRANCH.
  - 1000, 1100–1111 → EXEC.
  - Otherwise: illegal_op = 1 for this cycle → FETCH.
- EXEC: ALUop per opcode:
  - 1000: ALUop = func[6:0].
  - 1100: 0000010, immdSel = 1.
  - 1101: 0000100, immdSel = 1.
  - 1110: 0001000, immdSel = 1.
  - 1111: 0010000, immdSel = 1.
  - Next state:
    - opcode 1000 with func[7] = 1: window <= func[WIN_W-1:0] at end of cycle → FETCH.
    - opcode 1000 with func[7:6] = 01: compare-only → FETCH.
    - All other cases → WB.
- WB: ALUop and immdSel held from EXEC, reg_write = 1, memOrALU = 1 → FETCH.
- MEM: mem_req = 1, iord = 1, mem_write = (opcode == 0001), ALUop = 0.
  - On mem_ack: load → LWB; store → FETCH.
- LWB: reg_write = 1, memOrALU = 0 → FETCH.
- JUMP: pc_write = 1, pc_src = 1 → FETCH.
- BRANCH: ALUop = 1000111, pc_src = 2, pc_write = alu_zero → FETCH.
- Latency with zero-wait memory, counting FETCH through the last state:
  - ALU write: 4 cycles. Load: 4 cycles. Store / jump / branch / window op / compare: 3 cycles.
- Outputs are combinational from state, opcode and func. Default for any output not listed in a state: 0, except memOrALU = 1.
- Watchdog:
  - Counter clears on every transition into FETCH or MEM.
  - It increments each cycle in FETCH/MEM without mem_ack.
  - mem_ack wins over a simultaneous timeout.
  - If the counter equals TIMEOUT in FETCH or MEM with mem_ack low → FAULT at the next edge.
- FAULT: fault = 1, all strobes 0. Absorbing until rst.
- Window pointer wraps naturally modulo 2^WIN_W. It changes only in EXEC and is unaffected by illegal or faulted instructions.
- rst asserted mid-instruction: immediate return to the reset values above, with no partial writes completed.

Test Plan:
- Reset, zero-wait memory, opcode 1100 → states IDLE,FETCH,DECODE,EXEC,WB; EXEC ALUop = 0000010 with immdSel = 1; WB reg_write = 1, memOrALU = 1; next FETCH at cycle 5.
- Load (0000) with mem_ack delayed 3 cycles in MEM → mem_req/iord held high 4 cycles, mem_write = 0; LWB reg_write = 1, memOrALU = 0. Store (0001) → mem_write = 1, no reg_write, back to FETCH.
- Opcode 1000, func = 8'b1000_0011 → window becomes 3 after EXEC, no reg_write. Then func = 8'b0100_0001 → no write, window still 3. Then func = 8'b0000_0110 → reg_write = 1, ALUop = 0000110.
- Opcode 0100 with alu_zero = 1 → BRANCH pc_write = 1, pc_src = 2; repeated with alu_zero = 0 → pc_write = 0. Opcode 0010 → pc_write = 1, pc_src = 1.
- Opcode 0101 → illegal_op pulse in DECODE, no other strobe, FETCH next.
- Watchdog:
  - TIMEOUT = 4 with mem_ack never asserted in FETCH → fault = 1 at the 5th FETCH cycle's edge, mem_req = 0 thereafter.
  - mem_ack exactly on the timeout cycle → no fault.
  - rst low then high → IDLE, fault = 0, window = 0.
